csr_mtrap_file: RTL and testbench

- Parametrised machine-mode CSR file: successor to the single-port CSR block.
- Adds read-modify-write CSR ops (RW/RS/RC), hardware trap entry and mret state updates, and free-running mcycle/minstret counters.
- Adds registered timer/software interrupt pending bits, an interrupt-request output, and vectored mtvec.
- Sits beside the execute/commit stage; the commit stage drives trap/mret/instret, and the CSR instruction path drives the op port.

---
 rtl/csr_mtrap_file.sv | 191 +++++++++++++++++++
 tb/tb_csr_mtrap_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/csr_mtrap_file.sv
// csr_mtrap_file: machine-mode CSR file with trap entry, mret, counters and interrupt pending state
module csr_mtrap_file #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter logic [63:0]     MISA_VAL    = 64'h8000000000000100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            mtip_i,
  input  logic            msip_i,
  output logic            irq_o,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [1:0]  OP_RW       = 2'b01;
  localparam logic [1:0]  OP_RS       = 2'b10;
  localparam logic [XLEN-1:0] LOW2    = XLEN'(3);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_msie_q, mie_msie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic            mip_msip_q, mip_msip_d;
  logic            mip_mtip_q, mip_mtip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic [XLEN-1:0] mstatus_v, mie_v, mip_v, rd_val, wr_val, mtvec_base;
  logic            impl, wr;

  // architectural views of the packed single-bit fields
  always_comb begin
    mstatus_v        = '0;
    mstatus_v[3]     = mstatus_mie_q;
    mstatus_v[7]     = mstatus_mpie_q;
    mstatus_v[12:11] = 2'b11;
    mie_v            = '0;
    mie_v[3]         = mie_msie_q;
    mie_v[7]         = mie_mtie_q;
    mip_v            = '0;
    mip_v[3]         = mip_msip_q;
    mip_v[7]         = mip_mtip_q;
  end

  // read mux and implemented-address decode
  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (csr_addr_i)
      A_MSTATUS:   rd_val = mstatus_v;
      A_MISA:      rd_val = MISA_VAL[XLEN-1:0];
      A_MIE:       rd_val = mie_v;
      A_MTVEC:     rd_val = mtvec_q;
      A_MSCRATCH:  rd_val = mscratch_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = mcause_q;
      A_MTVAL:     rd_val = mtval_q;
      A_MIP:       rd_val = mip_v;
      A_MCYCLE:    rd_val = mcycle_q;
      A_MINSTRET:  rd_val = minstret_q;
      A_MVENDORID: rd_val = '0;
      A_MARCHID:   rd_val = '0;
      A_MIMPID:    rd_val = '0;
      A_MHARTID:   rd_val = HARTID;
      default:     impl   = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_en_i && (!impl || (csr_op_i != 2'b00 &&
                         (csr_addr_i[11:10] == 2'b11 || csr_addr_i == A_MIP)));
  assign csr_rdata_o   = csr_illegal_o ? '0 : rd_val;
  assign wr_val        = csr_op_i == OP_RW ? csr_wdata_i :
                         csr_op_i == OP_RS ? (rd_val | csr_wdata_i) : (rd_val & ~csr_wdata_i);
  assign wr            = csr_en_i && csr_op_i != 2'b00 && !csr_illegal_o && !trap_i && !mret_i;
  assign mtvec_base    = mtvec_q & ~LOW2;
  assign trap_vec_o    = mret_i ? mepc_q :
                         (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1]) ?
                         mtvec_base + {trap_cause_i[XLEN-3:0], 2'b00} : mtvec_base;
  assign irq_o         = mstatus_mie_q && ((mie_mtie_q && mip_mtip_q) || (mie_msie_q && mip_msip_q));
  assign mepc_o        = mepc_q;

  // next state: trap beats mret beats CSR write; counters and pending bits always advance
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_msie_d     = mie_msie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mip_msip_d     = msip_i;
    mip_mtip_d     = mtip_i;
    mcycle_d       = (wr && csr_addr_i == A_MCYCLE) ? wr_val : mcycle_q + XLEN'(1);
    minstret_d     = (wr && csr_addr_i == A_MINSTRET) ? wr_val : minstret_q + XLEN'(instret_i);
    if (trap_i) begin
      mepc_d         = trap_pc_i & ~LOW2;
      mcause_d       = trap_cause_i;
      mtval_d        = trap_tval_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          mstatus_mie_d  = wr_val[3];
          mstatus_mpie_d = wr_val[7];
        end
        A_MIE: begin
          mie_msie_d = wr_val[3];
          mie_mtie_d = wr_val[7];
        end
        A_MTVEC:    mtvec_d    = {wr_val[XLEN-1:2], wr_val[1] ? 2'b00 : wr_val[1:0]};
        A_MSCRATCH: mscratch_d = wr_val;
        A_MEPC:     mepc_d     = wr_val & ~LOW2;
        A_MCAUSE:   mcause_d   = wr_val;
        A_MTVAL:    mtval_d    = wr_val;
        default:    ;
      endcase
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_msie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mip_msip_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_msie_q     <= mie_msie_d;
      mie_mtie_q     <= mie_mtie_d;
      mip_msip_q     <= mip_msip_d;
      mip_mtip_q     <= mip_mtip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end
endmodule

// File: tb/tb_csr_mtrap_file.sv
// tb_csr_mtrap_file: directed and randomized checks of csr_mtrap_file against an address-keyed CSR model
module tb_csr_mtrap_file;
  localparam logic [63:0] MTV  = 64'h2001;
  localparam logic [63:0] HID  = 64'd3;
  localparam logic [63:0] MISA = 64'h8000000000000100;

  logic        clk = 1'b0, rst = 1'b0;
  logic        csr_en, trap, mret, instret, mtip, msip;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, trap_cause, trap_pc, trap_tval;
  logic [63:0] csr_rdata, trap_vec, mepc;
  logic        csr_illegal, irq;

  csr_mtrap_file #(.XLEN(64), .MTVEC_RESET(MTV), .HARTID(HID), .MISA_VAL(MISA)) dut (
    .clk(clk), .rst(rst), .csr_en_i(csr_en), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .trap_tval_i(trap_tval),
    .mret_i(mret), .instret_i(instret), .mtip_i(mtip), .msip_i(msip),
    .irq_o(irq), .trap_vec_o(trap_vec), .mepc_o(mepc)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [63:0] m [int];
  logic [63:0] l_rd, l_vec, l_mepc;
  logic        l_ill, l_irq;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic model_reset();
    m.delete();
    m['h300] = 64'h1800; m['h301] = MISA; m['h304] = 0; m['h305] = MTV;
    m['h340] = 0; m['h341] = 0; m['h342] = 0; m['h343] = 0; m['h344] = 0;
    m['hB00] = 0; m['hB02] = 0;
    m['hF11] = 0; m['hF12] = 0; m['hF13] = 0; m['hF14] = HID;
  endtask

  function automatic logic [63:0] rd_m(input int a);
    return m.exists(a) ? m[a] : 64'd0;
  endfunction

  function automatic logic legal(input int a, input logic [1:0] o);
    return m.exists(a) != 0 && !(o != 2'b00 && ((a >> 10) == 3 || a == 'h344));
  endfunction

  function automatic logic [63:0] legalize(input int a, input logic [63:0] v);
    case (a)
      'h300:   return (v & 64'h88) | 64'h1800;
      'h301:   return MISA;
      'h304:   return v & 64'h88;
      'h305:   return v[1] ? (v & ~64'h3) : v;
      'h341:   return v & ~64'h3;
      default: return v;
    endcase
  endfunction

  task automatic cyc(input logic e, input logic [1:0] o, input int a, input logic [63:0] d,
                     input logic t, input logic [63:0] c, input logic [63:0] p, input logic [63:0] v,
                     input logic r, input logic ir, input logic ti, input logic si);
    logic        x_ill, x_irq;
    logic [63:0] tv, ms, x_vec, old, nv, ncyc, nins;
    csr_en = e; csr_op = o; csr_addr = a[11:0]; csr_wdata = d;
    trap = t; trap_cause = c; trap_pc = p; trap_tval = v; mret = r;
    instret = ir; mtip = ti; msip = si;
    #1;
    x_ill = e && !legal(a, o);
    tv    = m['h305];
    ms    = m['h300];
    x_vec = r ? m['h341] : (tv[1:0] == 2'b01 && c[63]) ? (tv & ~64'h3) + (c << 2) : (tv & ~64'h3);
    x_irq = ms[3] && ((m['h304] & m['h344] & 64'h88) != 0);
    chk("illegal", {63'd0, csr_illegal}, {63'd0, x_ill});
    if (e) chk("rdata", csr_rdata, x_ill ? 64'd0 : rd_m(a));
    chk("trap_vec", trap_vec, x_vec);
    chk("irq", {63'd0, irq}, {63'd0, x_irq});
    chk("mepc_o", mepc, m['h341]);
    l_rd = csr_rdata; l_vec = trap_vec; l_mepc = mepc; l_ill = csr_illegal; l_irq = irq;
    @(posedge clk);
    old  = rd_m(a);
    nv   = o == 2'b01 ? d : o == 2'b10 ? (old | d) : (old & ~d);
    ncyc = m['hB00] + 64'd1;
    nins = m['hB02] + {63'd0, ir};
    m['hB00] = ncyc;
    m['hB02] = nins;
    m['h344] = ({63'd0, ti} << 7) | ({63'd0, si} << 3);
    if (t) begin
      m['h341] = p & ~64'h3;
      m['h342] = c;
      m['h343] = v;
      m['h300] = 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
    end else if (r) begin
      m['h300] = 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
    end else if (e && o != 2'b00 && legal(a, o)) begin
      m[a] = legalize(a, nv);
    end
    @(negedge clk);
  endtask

  task automatic rd(input int a);
    cyc(1, 2'b00, a, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [1:0] o, input logic [63:0] d);
    cyc(1, o, a, d, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int addrs[19] = '{'h300, 'h301, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344,
                    'hB00, 'hB02, 'hF11, 'hF12, 'hF13, 'hF14, 'h7C0, 'h000, 'hC00, 'h306};

  initial begin
    logic [63:0] d, c;
    {csr_en, trap, mret, instret, mtip, msip} = '0;
    csr_op = 0; csr_addr = 0; csr_wdata = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset irq", {63'd0, irq}, 64'd0);
    chk("reset mepc", mepc, 64'd0);
    rst = 1'b1;
    rd('h300); chk("reset mstatus", l_rd, 64'h1800);
    rd('h305); chk("reset mtvec", l_rd, MTV);
    repeat (8) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd('hB00); chk("mcycle after 10", l_rd, 64'd10);
    wr('h340, 2'b01, 64'hDEADBEEF);
    wr('h340, 2'b10, 64'hF0); chk("rs old", l_rd, 64'hDEADBEEF);
    wr('h340, 2'b11, 64'h0F); chk("rc old", l_rd, 64'hDEADBEFF);
    rd('h340); chk("rc result", l_rd, 64'hDEADBEF0);
    wr('h300, 2'b01, 64'h8);
    wr('h304, 2'b01, 64'h80);
    wr('h305, 2'b01, 64'h1001);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); chk("irq cycle N", {63'd0, l_irq}, 64'd0);
    cyc(0, 0, 0, 0, 1, 64'h8000000000000007, 64'h80000006, 64'h77, 0, 0, 1, 0);
    chk("irq cycle N+1", {63'd0, l_irq}, 64'd1);
    chk("vectored target", l_vec, 64'h101C);
    rd('h300); chk("mstatus after trap", l_rd, 64'h1880);
    chk("irq after trap", {63'd0, l_irq}, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("mret target", l_vec, 64'h80000004);
    chk("mepc aligned", l_mepc, 64'h80000004);
    rd('h300); chk("mstatus after mret", l_rd, 64'h1888);
    wr('hB00, 2'b01, '1);
    rd('hB00); chk("mcycle max", l_rd, '1);
    rd('hB00); chk("mcycle wrap", l_rd, 64'd0);
    cyc(1, 2'b01, 'hB02, 64'd5, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 2'b00, 'hB02, 0, 0, 0, 0, 0, 0, 1, 0, 0); chk("minstret write", l_rd, 64'd5);
    cyc(1, 2'b00, 'hB02, 0, 0, 0, 0, 0, 0, 1, 0, 0); chk("minstret resume", l_rd, 64'd6);
    wr('hF14, 2'b01, 64'h55); chk("mhartid write illegal", {63'd0, l_ill}, 64'd1);
    rd('hF14); chk("mhartid kept", l_rd, HID);
    wr('h7C0, 2'b01, 64'h55); chk("unimpl illegal", {63'd0, l_ill}, 64'd1);
    chk("unimpl rdata", l_rd, 64'd0);
    cyc(1, 2'b01, 'h340, 64'h1234, 1, 64'd2, 64'h100, 0, 0, 0, 0, 0);
    chk("write in trap legal", {63'd0, l_ill}, 64'd0);
    rd('h340); chk("mscratch kept in trap", l_rd, 64'hDEADBEF0);
    for (int i = 0; i < 2000; i++) begin
      d = ($urandom % 3 == 0) ? 64'($urandom % 16) : {$urandom, $urandom};
      c = ($urandom % 2 == 0) ? {1'b1, 59'd0, 4'($urandom)} : {$urandom, $urandom};
      cyc($urandom % 4 != 0, 2'($urandom), addrs[$urandom % 19], d,
          $urandom % 16 == 0, c, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom % 12 == 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
